// File: rtl/mmio_bridge_if.sv
// CPU-side memory bus: byte address, write strobe, write data and combinational read data.
interface mmio_bridge_if;
    logic [31:0] Bus_addr;
    logic        Bus_wen;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;

    modport master (output Bus_addr, output Bus_wen, output Bus_wdata, input Bus_rdata);
    modport slave  (input Bus_addr, input Bus_wen, input Bus_wdata, output Bus_rdata);
endinterface

// File: rtl/mmio_bridge.sv
// Bus responder: decodes CPU accesses to data RAM or the peripheral page and owns the
// LED register, input synchronizers, seven-segment scanner and programmable timer.
module mmio_bridge #(
    parameter int unsigned SCAN_DIV  = 20000,
    parameter logic [31:0] DIV_RESET = 32'd0
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    mmio_bridge_if.slave       bus,
    output logic [13:0]        dram_addr,
    input  logic [31:0]        dram_rdata,
    output logic               dram_we,
    output logic [31:0]        dram_wdata,
    input  logic [23:0]        sw,
    input  logic [4:0]         btn,
    output logic [23:0]        led,
    output logic [7:0]         dig_en,
    output logic [7:0]         dig_seg
);

    localparam logic [9:0] OFF_DIG  = 10'h000;
    localparam logic [9:0] OFF_TCNT = 10'h008;
    localparam logic [9:0] OFF_TDIV = 10'h009;
    localparam logic [9:0] OFF_LED  = 10'h018;
    localparam logic [9:0] OFF_SW   = 10'h01C;
    localparam logic [9:0] OFF_BTN  = 10'h01E;
    localparam logic [31:0] SCAN_LAST = 32'(SCAN_DIV - 1);

    // Active-low segment pattern {dp,g,f,e,d,c,b,a} for one hex digit, dp off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    logic        page_s;
    logic [9:0]  off_s;
    logic        unused_addr_s;
    logic        we_dig_s;
    logic        we_tcnt_s;
    logic        we_tdiv_s;
    logic        we_led_s;
    logic [31:0] rd_per_s;
    logic        tick_s;

    logic [31:0] dig_r;
    logic [31:0] tcnt_r;
    logic [31:0] tdiv_r;
    logic [31:0] presc_r;
    logic [23:0] led_r;
    logic [23:0] sw_meta_r;
    logic [23:0] sw_sync_r;
    logic [4:0]  btn_meta_r;
    logic [4:0]  btn_sync_r;
    logic [31:0] scan_cnt_r;
    logic [2:0]  idx_r;
    logic [7:0]  dig_en_r;
    logic [7:0]  dig_seg_r;

    assign page_s        = (bus.Bus_addr[31:12] == 20'hFFFFF);
    assign off_s         = bus.Bus_addr[11:2];
    assign unused_addr_s = ^bus.Bus_addr[1:0];

    assign dram_addr  = bus.Bus_addr[15:2];
    assign dram_wdata = bus.Bus_wdata;
    assign dram_we    = bus.Bus_wen & ~page_s;

    assign led     = led_r;
    assign dig_en  = dig_en_r;
    assign dig_seg = dig_seg_r;

    // Peripheral decode: per-register write strobes and read mux.
    always_comb begin
        we_dig_s  = 1'b0;
        we_tcnt_s = 1'b0;
        we_tdiv_s = 1'b0;
        we_led_s  = 1'b0;
        rd_per_s  = 32'd0;
        if (page_s) begin
            case (off_s)
                OFF_DIG:  begin rd_per_s = dig_r;                 we_dig_s  = bus.Bus_wen; end
                OFF_TCNT: begin rd_per_s = tcnt_r;                we_tcnt_s = bus.Bus_wen; end
                OFF_TDIV: begin rd_per_s = tdiv_r;                we_tdiv_s = bus.Bus_wen; end
                OFF_LED:  begin rd_per_s = {8'd0, led_r};         we_led_s  = bus.Bus_wen; end
                OFF_SW:   begin rd_per_s = {8'd0, sw_sync_r};     end
                OFF_BTN:  begin rd_per_s = {27'd0, btn_sync_r};   end
                default:  begin rd_per_s = 32'd0;                 end
            endcase
        end else begin
            rd_per_s = 32'd0;
        end
    end

    assign bus.Bus_rdata = page_s ? rd_per_s : dram_rdata;

    // A zero divider halts the timer entirely.
    assign tick_s = (tdiv_r != 32'd0) && (presc_r == (tdiv_r - 32'd1));

    // DIG and LED registers.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            dig_r <= 32'd0;
            led_r <= 24'd0;
        end else begin
            if (we_dig_s) dig_r <= bus.Bus_wdata;
            if (we_led_s) led_r <= bus.Bus_wdata[23:0];
        end
    end

    // Timer: a TCNT write overrides a coincident tick; any timer write restarts the prescaler.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            tcnt_r  <= 32'd0;
            tdiv_r  <= DIV_RESET;
            presc_r <= 32'd0;
        end else begin
            if (we_tdiv_s) tdiv_r <= bus.Bus_wdata;
            if (we_tcnt_s)   tcnt_r <= bus.Bus_wdata;
            else if (tick_s) tcnt_r <= tcnt_r + 32'd1;
            if (we_tcnt_s || we_tdiv_s || tick_s) presc_r <= 32'd0;
            else if (tdiv_r != 32'd0)              presc_r <= presc_r + 32'd1;
        end
    end

    // Two-flop synchronizers for switches and buttons.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            sw_meta_r  <= 24'd0;
            sw_sync_r  <= 24'd0;
            btn_meta_r <= 5'd0;
            btn_sync_r <= 5'd0;
        end else begin
            sw_meta_r  <= sw;
            sw_sync_r  <= sw_meta_r;
            btn_meta_r <= btn;
            btn_sync_r <= btn_meta_r;
        end
    end

    // Digit scanner with registered enable/segment outputs.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            scan_cnt_r <= 32'd0;
            idx_r      <= 3'd0;
            dig_en_r   <= 8'hFF;
            dig_seg_r  <= 8'hFF;
        end else begin
            if (scan_cnt_r == SCAN_LAST) begin
                scan_cnt_r <= 32'd0;
                idx_r      <= idx_r + 3'd1;
            end else begin
                scan_cnt_r <= scan_cnt_r + 32'd1;
            end
            dig_en_r  <= ~(8'b0000_0001 << idx_r);
            dig_seg_r <= hex_to_seg(dig_r[{idx_r, 2'b00} +: 4]);
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed self-checking bench for mmio_bridge; a second instance with SCAN_DIV=2 checks display content.
module tb_mmio_bridge;
    logic        clk;
    logic        rst;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [4:0]  btn;

    logic [13:0] dram_addr_a, dram_addr_b;
    logic        dram_we_a, dram_we_b;
    logic [31:0] dram_wdata_a, dram_wdata_b;
    logic [23:0] led_a, led_b;
    logic [7:0]  dig_en_a, dig_en_b, dig_seg_a, dig_seg_b;

    int tests;
    int fails;

    mmio_bridge_if bus_a ();
    mmio_bridge_if bus_b ();

    assign bus_b.Bus_addr  = bus_a.Bus_addr;
    assign bus_b.Bus_wen   = bus_a.Bus_wen;
    assign bus_b.Bus_wdata = bus_a.Bus_wdata;

    mmio_bridge #(.SCAN_DIV(4)) dut_a (
        .cpu_clk(clk), .cpu_rst(rst), .bus(bus_a),
        .dram_addr(dram_addr_a), .dram_rdata(dram_rdata), .dram_we(dram_we_a),
        .dram_wdata(dram_wdata_a), .sw(sw), .btn(btn), .led(led_a),
        .dig_en(dig_en_a), .dig_seg(dig_seg_a)
    );

    mmio_bridge #(.SCAN_DIV(2)) dut_b (
        .cpu_clk(clk), .cpu_rst(rst), .bus(bus_b),
        .dram_addr(dram_addr_b), .dram_rdata(dram_rdata), .dram_we(dram_we_b),
        .dram_wdata(dram_wdata_b), .sw(sw), .btn(btn), .led(led_b),
        .dig_en(dig_en_b), .dig_seg(dig_seg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp_en;
        rst = 1'b1;
        step(2);
        tests++; if (dig_en_a !== 8'hFF) begin fails++; $display("FAIL reset_dig_en got=%h exp=ff", dig_en_a); end
        tests++; if (dig_seg_a !== 8'hFF) begin fails++; $display("FAIL reset_dig_seg got=%h exp=ff", dig_seg_a); end
        tests++; if (led_a !== 24'h0) begin fails++; $display("FAIL reset_led got=%h exp=0", led_a); end
        bus_a.Bus_addr = 32'hFFFFF024; #1;
        tests++; if (bus_a.Bus_rdata !== 32'h0) begin fails++; $display("FAIL reset_tdiv got=%h exp=0", bus_a.Bus_rdata); end
        rst = 1'b0;
        step(1);
        tests++; if (dig_en_a !== 8'hFE) begin fails++; $display("FAIL first_dig_en got=%h exp=fe", dig_en_a); end
        step(3);
        tests++; if (dig_en_a !== 8'hFE) begin fails++; $display("FAIL dig_en_hold got=%h exp=fe", dig_en_a); end
        for (int k = 1; k <= 8; k++) begin
            step(4);
            exp_en = ~(8'b0000_0001 << (k % 8));
            tests++;
            if (dig_en_a !== exp_en) begin fails++; $display("FAIL scan_step%0d got=%h exp=%h", k, dig_en_a, exp_en); end
        end
    endtask

    task automatic test_ram();
        bus_a.Bus_addr = 32'h00000100; bus_a.Bus_wen = 1'b1; bus_a.Bus_wdata = 32'h12345678; #1;
        tests++; if (dram_we_a !== 1'b1) begin fails++; $display("FAIL ram_we got=%b exp=1", dram_we_a); end
        tests++; if (dram_addr_a !== 14'h040) begin fails++; $display("FAIL ram_addr got=%h exp=040", dram_addr_a); end
        tests++; if (dram_wdata_a !== 32'h12345678) begin fails++; $display("FAIL ram_wdata got=%h exp=12345678", dram_wdata_a); end
        step(1);
        bus_a.Bus_wen = 1'b0; dram_rdata = 32'h12345678; #1;
        tests++; if (bus_a.Bus_rdata !== 32'h12345678) begin fails++; $display("FAIL ram_read got=%h exp=12345678", bus_a.Bus_rdata); end
        tests++; if (led_a !== 24'h0) begin fails++; $display("FAIL ram_led got=%h exp=0", led_a); end
        bus_a.Bus_addr = 32'h00003FFC; #1;
        tests++; if (dram_addr_a !== 14'h0FFF) begin fails++; $display("FAIL ram_addr2 got=%h exp=0fff", dram_addr_a); end
    endtask

    task automatic test_led();
        bus_a.Bus_addr = 32'hFFFFF060; bus_a.Bus_wen = 1'b1; bus_a.Bus_wdata = 32'h00ABCDEF; #1;
        tests++; if (bus_a.Bus_rdata !== 32'h0) begin fails++; $display("FAIL led_same_cycle got=%h exp=0", bus_a.Bus_rdata); end
        tests++; if (dram_we_a !== 1'b0) begin fails++; $display("FAIL led_dram_we got=%b exp=0", dram_we_a); end
        step(1);
        bus_a.Bus_wen = 1'b0; #1;
        tests++; if (led_a !== 24'hABCDEF) begin fails++; $display("FAIL led_out got=%h exp=abcdef", led_a); end
        tests++; if (bus_a.Bus_rdata !== 32'h00ABCDEF) begin fails++; $display("FAIL led_read got=%h exp=00abcdef", bus_a.Bus_rdata); end
    endtask

    task automatic test_timer();
        bus_a.Bus_addr = 32'hFFFFF024; bus_a.Bus_wen = 1'b1; bus_a.Bus_wdata = 32'd3;
        step(1);
        bus_a.Bus_addr = 32'hFFFFF020; bus_a.Bus_wdata = 32'hFFFFFFFE;
        step(1);
        bus_a.Bus_wen = 1'b0; #1;
        tests++; if (bus_a.Bus_rdata !== 32'hFFFFFFFE) begin fails++; $display("FAIL tcnt_load got=%h exp=fffffffe", bus_a.Bus_rdata); end
        step(2);
        tests++; if (bus_a.Bus_rdata !== 32'hFFFFFFFE) begin fails++; $display("FAIL tcnt_hold got=%h exp=fffffffe", bus_a.Bus_rdata); end
        step(1);
        tests++; if (bus_a.Bus_rdata !== 32'hFFFFFFFF) begin fails++; $display("FAIL tcnt_tick1 got=%h exp=ffffffff", bus_a.Bus_rdata); end
        step(3);
        tests++; if (bus_a.Bus_rdata !== 32'h0) begin fails++; $display("FAIL tcnt_wrap got=%h exp=0", bus_a.Bus_rdata); end
        step(2);
        bus_a.Bus_wen = 1'b1; bus_a.Bus_wdata = 32'h55; #1;
        tests++; if (bus_a.Bus_rdata !== 32'h0) begin fails++; $display("FAIL tcnt_same_cycle got=%h exp=0", bus_a.Bus_rdata); end
        step(1);
        bus_a.Bus_wen = 1'b0; #1;
        tests++; if (bus_a.Bus_rdata !== 32'h55) begin fails++; $display("FAIL tcnt_write_vs_tick got=%h exp=55", bus_a.Bus_rdata); end
        step(3);
        tests++; if (bus_a.Bus_rdata !== 32'h56) begin fails++; $display("FAIL tcnt_after_load got=%h exp=56", bus_a.Bus_rdata); end
        bus_a.Bus_addr = 32'hFFFFF024; bus_a.Bus_wen = 1'b1; bus_a.Bus_wdata = 32'd0;
        step(1);
        bus_a.Bus_wen = 1'b0; bus_a.Bus_addr = 32'hFFFFF020;
        step(8);
        tests++; if (bus_a.Bus_rdata !== 32'h56) begin fails++; $display("FAIL tcnt_frozen got=%h exp=56", bus_a.Bus_rdata); end
    endtask

    task automatic test_sw_btn();
        sw = 24'h000001; btn = 5'h15; bus_a.Bus_addr = 32'hFFFFF070; #1;
        tests++; if (bus_a.Bus_rdata !== 32'h0) begin fails++; $display("FAIL sw_edge0 got=%h exp=0", bus_a.Bus_rdata); end
        step(1);
        tests++; if (bus_a.Bus_rdata !== 32'h0) begin fails++; $display("FAIL sw_edge1 got=%h exp=0", bus_a.Bus_rdata); end
        step(1);
        tests++; if (bus_a.Bus_rdata !== 32'h1) begin fails++; $display("FAIL sw_edge2 got=%h exp=1", bus_a.Bus_rdata); end
        bus_a.Bus_addr = 32'hFFFFF078; #1;
        tests++; if (bus_a.Bus_rdata !== 32'h15) begin fails++; $display("FAIL btn_read got=%h exp=15", bus_a.Bus_rdata); end
        bus_a.Bus_addr = 32'hFFFFF070; bus_a.Bus_wen = 1'b1; bus_a.Bus_wdata = 32'hFFFFFFFF;
        step(1);
        bus_a.Bus_addr = 32'hFFFFF100; #1;
        tests++; if (dram_we_a !== 1'b0) begin fails++; $display("FAIL unmapped_dram_we got=%b exp=0", dram_we_a); end
        step(1);
        bus_a.Bus_wen = 1'b0; #1;
        tests++; if (bus_a.Bus_rdata !== 32'h0) begin fails++; $display("FAIL unmapped_read got=%h exp=0", bus_a.Bus_rdata); end
        bus_a.Bus_addr = 32'hFFFFF070; #1;
        tests++; if (bus_a.Bus_rdata !== 32'h1) begin fails++; $display("FAIL sw_readonly got=%h exp=1", bus_a.Bus_rdata); end
        bus_a.Bus_addr = 32'hFFFFF060; #1;
        tests++; if (bus_a.Bus_rdata !== 32'h00ABCDEF) begin fails++; $display("FAIL led_untouched got=%h exp=00abcdef", bus_a.Bus_rdata); end
    endtask

    task automatic test_dig();
        logic [7:0] exp_seg [8];
        logic [7:0] want;
        int idx;
        exp_seg = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
        bus_a.Bus_addr = 32'hFFFFF000; bus_a.Bus_wen = 1'b1; bus_a.Bus_wdata = 32'h0000000F;
        step(1);
        bus_a.Bus_wen = 1'b0;
        step(1);
        tests++; if (bus_a.Bus_rdata !== 32'h0000000F) begin fails++; $display("FAIL dig_read got=%h exp=0000000f", bus_a.Bus_rdata); end
        for (int c = 0; c < 20; c++) begin
            want = (dig_en_b == 8'hFE) ? 8'h8E : 8'hC0;
            tests++;
            if (dig_seg_b !== want) begin fails++; $display("FAIL dig_f_cyc%0d en=%h got=%h exp=%h", c, dig_en_b, dig_seg_b, want); end
            step(1);
        end
        bus_a.Bus_wen = 1'b1; bus_a.Bus_wdata = 32'h89ABCDEF;
        step(1);
        bus_a.Bus_wen = 1'b0;
        step(1);
        for (int c = 0; c < 20; c++) begin
            idx = -1;
            for (int d = 0; d < 8; d++) begin
                if (dig_en_b == ~(8'b0000_0001 << d)) idx = d;
            end
            tests++;
            if (idx < 0) begin
                fails++; $display("FAIL dig_en_onehot cyc%0d got=%h exp=one-hot-low", c, dig_en_b);
            end else if (dig_seg_b !== exp_seg[idx]) begin
                fails++; $display("FAIL dig_pattern cyc%0d digit=%0d got=%h exp=%h", c, idx, dig_seg_b, exp_seg[idx]);
            end
            step(1);
        end
    endtask

    task automatic test_reset_write();
        rst = 1'b1;
        bus_a.Bus_addr = 32'hFFFFF060; bus_a.Bus_wen = 1'b1; bus_a.Bus_wdata = 32'h00000123;
        step(1);
        rst = 1'b0; bus_a.Bus_wen = 1'b0; #1;
        tests++; if (led_a !== 24'h0) begin fails++; $display("FAIL reset_write_led got=%h exp=0", led_a); end
        tests++; if (dig_seg_a !== 8'hFF) begin fails++; $display("FAIL reset_write_seg got=%h exp=ff", dig_seg_a); end
        bus_a.Bus_addr = 32'hFFFFF000; #1;
        tests++; if (bus_a.Bus_rdata !== 32'h0) begin fails++; $display("FAIL reset_write_dig got=%h exp=0", bus_a.Bus_rdata); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        dram_rdata = 32'h0;
        sw = 24'h0;
        btn = 5'h0;
        bus_a.Bus_addr = 32'h0;
        bus_a.Bus_wen = 1'b0;
        bus_a.Bus_wdata = 32'h0;
        test_reset();
        test_ram();
        test_led();
        test_timer();
        test_sw_btn();
        test_dig();
        test_reset_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Bus responder that sits on the far side of the CPU's `Bus_addr`/`Bus_wen`/`Bus_wdata`/`Bus_rdata` port. It decodes each access to either data RAM or a memory-mapped peripheral page and returns read data combinationally, in the same cycle as the CPU's MEM stage. It commits writes on the clock edge. It also owns the sequential peripherals: LED register, switch/button synchronizers, an 8-digit seven-segment scanner and a programmable timer.

## Interface
Parameters:
- `SCAN_DIV`, 20000: `cpu_clk` cycles each seven-segment digit is lit; must be ≥ 2.
- `DIV_RESET`, 0: reset value of the timer divider register; 0 means the timer is halted.

Ports:
- `cpu_clk`  in  1  the single clock; all state changes on its rising edge.
- `cpu_rst`  in  1  reset, synchronous and active-high.
- `Bus_addr`  in  32  byte address from the CPU; word accesses only, bits [1:0] ignored.
- `Bus_wen`  in  1  write strobe for the current cycle.
- `Bus_wdata`  in  32  write data.
- `Bus_rdata`  out  32  read data, combinational from `Bus_addr`.
- `dram_addr`  out  14  word address to data RAM, equal to `Bus_addr[15:2]`.
- `dram_rdata`  in  32  asynchronous RAM read data.
- `dram_we`  out  1  RAM write enable.
- `dram_wdata`  out  32  equal to `Bus_wdata`.
- `sw`  in  24  raw switch inputs.
- `btn`  in  5  raw button inputs.
- `led`  out  24  LED register.
- `dig_en`  out  8  digit enables, active-low, one-hot.
- `dig_seg`  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.

## Operation
Decode:
- The peripheral page is `Bus_addr[31:12] == 20'hFFFFF`.
- Every address outside the peripheral page is RAM. `dram_we = Bus_wen & ~page`.

Peripheral page, selected by `Bus_addr[11:0]`:
- 0x000 DIG: read/write, 32 bits, holds eight hex nibbles. Digit i shows nibble [4i+3:4i].
- 0x020 TCNT: read/write.
  - A write loads the count and clears the prescaler.
  - A read returns the live count.
- 0x024 TDIV: read/write. A write also clears the prescaler.
- 0x060 LED: read/write. The low 24 bits drive `led`; a read returns {8'b0, led}.
- 0x070 SW: read-only, returns {8'b0, sw_sync}.
- 0x078 BTN: read-only, returns {27'b0, btn_sync}.
- Any other page offset reads 0. Writes to it, and writes to SW or BTN, are ignored.

Synchronizers:
- `sw` and `btn` each pass through a 2-flop synchronizer.
- Reads and all internal logic use only the second stage.

Timer:
- A 32-bit prescaler counts up to TDIV−1, then wraps to 0. On the wrap cycle TCNT increments by 1; TCNT wraps from 0xFFFFFFFF to 0.
- When TDIV == 0, the prescaler and TCNT are frozen.
- A bus write to TCNT in the same cycle as a tick: the written value wins and the tick is lost.

Scanner:
- A scan counter runs 0..SCAN_DIV−1.
- On wrap, the digit index (3 bits, 0..7) advances, wrapping from 7 to 0.
- `dig_en` and `dig_seg` are registered: at each edge they load the enable and hex-decoded pattern for the current index and the current DIG contents.
- Hex patterns (active-low, dp always off): 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, B→83, C→C6, D→A1, E→86, F→8E.

## Timing
Reset (synchronous, active-high):
- DIG, TCNT, LED, prescaler, scan counter, digit index and synchronizers are 0. TDIV = DIV_RESET.
- `dig_en` = 8'hFF and `dig_seg` = 8'hFF.
- `Bus_rdata` is never registered; it always follows the address combinationally.
- Reset asserted during any operation takes effect at the next edge and discards any same-cycle write.

Reads and writes:
- Read latency is zero: `Bus_rdata` is valid in the same cycle as `Bus_addr`.
- A write is visible from the edge that ends its cycle. A read of the same address in that same cycle returns the old value; a read in the following cycle returns the new value.
- RAM writes pass through in the same cycle (`dram_we` is combinational); the RAM itself commits at the edge.

Sync and display latency:
- A switch change is readable 2 edges after it settles.
- A DIG write reaches `dig_seg` at the earliest 1 edge later, when that digit is next selected.

Timer tick period: TCNT advances once every TDIV cycles.

## Test plan
- Reset with SCAN_DIV=4 → `dig_en`=FF and `dig_seg`=FF in the cycle after reset; `dig_en`=FE after the first edge out of reset; index advances every 4 cycles; FE→…→7F→FE.
- Write 0x12345678 to RAM address 0x00000100 → `dram_we`=1 and `dram_addr`=0x040 that cycle; reading the same address with `dram_rdata` driven returns it; `led` unchanged.
- Write 0x00ABCDEF to 0xFFFFF060 → `led`=ABCDEF next cycle; same-cycle read returns 0, next-cycle read returns 0x00ABCDEF; `dram_we` stays 0.
- Write TDIV=3, then TCNT=0xFFFFFFFE → TCNT reads FFFFFFFF after 3 cycles, 0 after 6; TCNT write coinciding with a tick loads the written value.
- Toggle `sw`=0x000001 → reads of 0xFFFFF070 return 0 for 2 edges, then 0x00000001; unmapped offset 0xFFFFF100 reads 0.
- DIG=0x0000000F, SCAN_DIV=2 → `dig_seg`=8E whenever `dig_en`=FE, and C0 when any other digit is enabled.
